uart_tx_byte: RTL and testbench
===============================

Name: uart_tx_byte

Overview:
- 8N1 UART transmitter that sits directly downstream of the up-counter.
- Accepts a one-cycle start pulse plus a data byte (counter's o_start_uart / o_uart_data) and serialises it onto a single TX line.
- Includes a one-entry pending buffer so a start pulse arriving mid-frame is not lost. Overruns beyond one pending byte are flagged.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200 baud); legal range >= 2; bit-period counter width = $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all logic on posedge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle request to send i_data.
- i_data  input  8  byte to send; sampled only in the cycle i_start=1.
- o_tx  output  1  serial line; idle high.
- o_busy  output  1  high while a frame is on the line or a byte is pending.
- o_done  output  1  one-cycle pulse when a frame's stop bit completes.
- o_overrun  output  1  one-cycle pulse when a start is dropped.

Behaviour:
Reset:
- i_reset=1 asynchronously forces: state IDLE, o_tx=1, o_busy=0, o_done=0, o_overrun=0, pending empty, bit counter=0, bit index=0.
- Reset mid-frame aborts the frame: o_tx goes high immediately, no o_done, pending byte discarded.

State machine (IDLE, START, DATA, STOP; all outputs registered):
- IDLE:
  - o_tx=1.
  - If i_start=1 at edge N, latch i_data into the shift register and go to START.
  - From cycle N+1, o_tx=0 and o_busy=1.
- START:
  - o_tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, each held CLKS_PER_BIT cycles.
  - Order is the numeric LSB of the byte first. Example: 0x41 sends 1,0,0,0,0,0,1,0.
  - After bit 7, go to STOP.
- STOP:
  - o_tx=1 for CLKS_PER_BIT cycles.
  - On the edge ending the last stop cycle, o_done=1 for the following single cycle.
  - If pending is valid, go straight to START with the pending byte; o_tx=0 in the same cycle o_done=1, with no idle gap.
  - Otherwise go to IDLE.

Frame timing:
- Frame length is exactly 10*CLKS_PER_BIT cycles from the first low cycle to the o_done cycle (exclusive).

Pending buffer (one entry):
- i_start=1 while state != IDLE with pending empty: capture i_data into pending, valid=1.
- i_start=1 while state != IDLE with pending full: byte dropped, pending unchanged, o_overrun=1 for one cycle.
- Simultaneous pending-valid and i_start on the final stop edge: pending byte starts transmitting and i_data refills pending (no overrun).
- i_start on the final stop edge with pending empty: i_data starts transmitting directly, back-to-back.
- i_start in IDLE never sets o_overrun.

Other rules:
- o_busy = (state != IDLE) or pending valid.
- Bit counter counts 0..CLKS_PER_BIT-1 and resets on every bit boundary. It never wraps mid-bit.
- i_data is ignored in cycles where i_start=0.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
1. Reset then idle 20 cycles -> o_tx=1, o_busy=0, o_done=0, o_overrun=0 throughout.
2. Single byte: i_start=1, i_data=0x41 at cycle 0 -> o_tx cycles 1-40 = 0 (x4), then 1,0,0,0,0,0,1,0 (x4 each), then 1 (x4). o_done high at cycle 41, o_busy low at cycle 41.
3. Back-to-back: send 0x55, pulse i_start with 0xA3 at cycle 10 -> o_busy stays 1. The second start bit begins at cycle 41, the same cycle as the first o_done. The second o_done is at cycle 81.
4. Overrun: send 0x00, then start 0x11 at cycle 5 and start 0x22 at cycle 8 -> o_overrun=1 at cycle 9 only. Frames 0x00 then 0x11 are sent; 0x22 is never sent.
5. Reset mid-frame: start 0xFF, queue 0x12, assert i_reset at cycle 15 for 2 cycles -> o_tx=1 immediately, o_busy=0, no o_done. After release, line stays idle until a new start.
6. Integration with counter (count compare scaled down) -> each o_start_uart pulse yields exactly one 0x41 frame and one o_done; o_overrun never asserts.

Source files
------------

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter with a one-entry pending buffer.
// A start request arriving while a frame is in flight is parked in the
// pending slot and launched with no idle gap after the current stop bit;
// a further request while the slot is full is dropped and flagged.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [7:0]    pend, pend_nx;
  logic          pend_v, pend_v_nx;
  logic          tx, tx_nx;
  logic          busy, busy_nx;
  logic          done, done_nx;
  logic          ovr, ovr_nx;
  logic          bit_end;
  logic          final_edge;

  assign bit_end    = (cnt == CNT_LAST);
  assign final_edge = (state == STOP) && bit_end;

  assign o_tx      = tx;
  assign o_busy    = busy;
  assign o_done    = done;
  assign o_overrun = ovr;

  // State and output registers; reset aborts any frame and empties the pending slot.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      tx     <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      shreg  <= shreg_nx;
      pend   <= pend_nx;
      pend_v <= pend_v_nx;
      tx     <= tx_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      ovr    <= ovr_nx;
    end
  end

  // Next-state, bit timing, pending-slot management and next output values.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    shreg_nx  = shreg;
    pend_nx   = pend;
    pend_v_nx = pend_v;
    tx_nx     = tx;
    done_nx   = 1'b0;
    ovr_nx    = 1'b0;

    // Mid-frame requests go to the pending slot; the final stop edge is
    // handled in STOP because the slot may be drained and refilled there.
    if (state != IDLE && !final_edge && i_start) begin
      if (!pend_v) begin
        pend_nx   = i_data;
        pend_v_nx = 1'b1;
      end else begin
        ovr_nx = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        tx_nx  = 1'b1;
        cnt_nx = '0;
        idx_nx = '0;
        if (i_start) begin
          shreg_nx = i_data;
          state_nx = START;
          tx_nx    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = DATA;
          tx_nx    = shreg[0];
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            idx_nx = idx + 3'd1;
            tx_nx  = shreg[idx_nx];
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nx  = '0;
          done_nx = 1'b1;
          if (pend_v) begin
            shreg_nx  = pend;
            state_nx  = START;
            tx_nx     = 1'b0;
            pend_nx   = i_start ? i_data : pend;
            pend_v_nx = i_start;
          end else if (i_start) begin
            shreg_nx = i_data;
            state_nx = START;
            tx_nx    = 1'b0;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase

    busy_nx = (state_nx != IDLE) || pend_v_nx;
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte with CLKS_PER_BIT=4.
// Cycle c is the clock period in which stimulus is driven; outputs are
// sampled on the falling edge of that same period, before new stimulus.
module tb_uart_tx_byte;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_data;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;
  logic       o_overrun;

  int total;
  int bad;

  uart_tx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_data    (i_data),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_overrun (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-frame vectors: byte and its hand-written line sequence
  // (MSB = start bit, then data LSB first, LSB = stop bit).
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int c, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0b want %0b", name, c, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int c, input logic etx,
                           input logic ebusy, input logic edone, input logic eovr);
    check({name, ".tx"},      c, o_tx,      etx);
    check({name, ".busy"},    c, o_busy,    ebusy);
    check({name, ".done"},    c, o_done,    edone);
    check({name, ".overrun"}, c, o_overrun, eovr);
  endtask

  // Drive up to three start pulses and check against up to three expected
  // frames (first-low cycle and line pattern); -1 marks an unused slot.
  task automatic run_script(input string name, input int ncyc,
                            input int sc0, input logic [7:0] sd0,
                            input int sc1, input logic [7:0] sd1,
                            input int sc2, input logic [7:0] sd2,
                            input int f0, input logic [9:0] l0,
                            input int f1, input logic [9:0] l1,
                            input int f2, input logic [9:0] l2,
                            input int ovc);
    int         sc[3];
    logic [7:0] sd[3];
    int         fc[3];
    logic [9:0] fl[3];
    logic       etx, ebusy, edone, eovr;
    sc[0] = sc0; sc[1] = sc1; sc[2] = sc2;
    sd[0] = sd0; sd[1] = sd1; sd[2] = sd2;
    fc[0] = f0;  fc[1] = f1;  fc[2] = f2;
    fl[0] = l0;  fl[1] = l1;  fl[2] = l2;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      etx   = 1'b1;
      ebusy = 1'b0;
      edone = 1'b0;
      eovr  = (c == ovc);
      for (int k = 0; k < 3; k++) begin
        if (fc[k] >= 0) begin
          if (c >= fc[k] && c < fc[k] + FL) begin
            etx   = fl[k][9 - (c - fc[k]) / CPB];
            ebusy = 1'b1;
          end
          if (c == fc[k] + FL) edone = 1'b1;
        end
      end
      check_all(name, c, etx, ebusy, edone, eovr);
      i_start = 1'b0;
      i_data  = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        if (sc[k] == c) begin
          i_start = 1'b1;
          i_data  = sd[k];
        end
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_data  = 8'h00;

    tbl[0] = '{8'h41, 10'b0100000101};
    tbl[1] = '{8'h00, 10'b0000000001};
    tbl[2] = '{8'hFF, 10'b0111111111};
    tbl[3] = '{8'h55, 10'b0101010101};
    tbl[4] = '{8'hA3, 10'b0110001011};
    tbl[5] = '{8'h80, 10'b0000000011};
    tbl[6] = '{8'h01, 10'b0100000001};

    // Reset state, then 20 idle cycles with the line high.
    #1;
    check_all("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_all("idle", c, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Single frames from the table.
    for (int v = 0; v < 7; v++) begin
      run_script($sformatf("frame_%02h", tbl[v].data), FL + 3,
                 0, tbl[v].data, -1, 8'h00, -1, 8'h00,
                 1, tbl[v].line, -1, 10'h0, -1, 10'h0, -1);
    end

    // Queued byte starts in the same cycle as the first done.
    run_script("b2b", 2 * FL + 3,
               0, 8'h55, 10, 8'hA3, -1, 8'h00,
               1, 10'b0101010101, 41, 10'b0110001011, -1, 10'h0, -1);

    // Third start while the slot is full is dropped and flagged once.
    run_script("overrun", 2 * FL + 8,
               0, 8'h00, 5, 8'h11, 8, 8'h22,
               1, 10'b0000000001, 41, 10'b0100010001, -1, 10'h0, 9);

    // Start on the final stop edge with the slot empty: sent back-to-back.
    run_script("edge_empty", 2 * FL + 3,
               0, 8'h80, 40, 8'h41, -1, 8'h00,
               1, 10'b0000000011, 41, 10'b0100000101, -1, 10'h0, -1);

    // Start on the final stop edge with the slot full: drain and refill.
    run_script("edge_refill", 3 * FL + 3,
               0, 8'h55, 10, 8'hA3, 40, 8'h01,
               1, 10'b0101010101, 41, 10'b0110001011, 81, 10'b0100000001, -1);

    // Counter-style periodic start pulses, each yielding one 0x41 frame.
    run_script("periodic", 2 * 50 + FL + 3,
               0, 8'h41, 50, 8'h41, 100, 8'h41,
               1, 10'b0100000101, 51, 10'b0100000101, 101, 10'b0100000101, -1);

    // Reset mid-frame with a byte queued: line idles, nothing resumes.
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c >= 1) check("rst_mid.tx", c, o_tx, (c <= CPB) ? 1'b0 : 1'b1);
      i_start = (c == 0) || (c == 3);
      i_data  = (c == 0) ? 8'hFF : 8'h12;
    end
    @(negedge clk);
    i_start = 1'b0;
    i_reset = 1'b1;
    #1;
    check_all("rst_mid.assert", 15, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("rst_mid.hold", 16, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    i_reset = 1'b0;
    for (int c = 18; c < 18 + 2 * FL; c++) begin
      @(negedge clk);
      check_all("rst_mid.after", c, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Line still works after the aborted frame.
    run_script("post_reset", FL + 3,
               0, 8'h41, -1, 8'h00, -1, 8'h00,
               1, 10'b0100000101, -1, 10'h0, -1, 10'h0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
